// File: rtl/plru_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : plru_pkg                                                     |
// | Description : Shared types and pure helper functions for the tree          |
// |               pseudo-LRU replacement engine (victim walk, MRU update,      |
// |               lowest-invalid-way search).                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package plru_pkg;

   // Upper bound on associativity the helpers can handle (128 ways).
   localparam int MAX_LEVEL = 7;
   localparam int MAX_WAYS  = 1 << MAX_LEVEL;
   localparam int MAX_NODES = MAX_WAYS - 1;

   // Callers zero-extend their narrower values into these and truncate results.
   typedef logic [MAX_NODES-1:0] tree_max_t;
   typedef logic [MAX_LEVEL-1:0] way_max_t;
   typedef logic [MAX_WAYS-1:0]  mask_max_t;

   // Request engine states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Walk from the root against each node's pointer; the inverted node values
   // along the path form the victim way, MSB at the root.
   function automatic way_max_t plru_victim(input tree_max_t tree, input int level);
      way_max_t way;
      int       node;
      logic     dir;
      way  = '0;
      node = 0;
      for (int l = 0; l < MAX_LEVEL; l++) begin
         if (l < level) begin
            dir                = ~tree[node];
            way[level - 1 - l] = dir;
            node               = 2 * node + 1 + int'(dir);
         end
      end
      return way;
   endfunction

   // Mark a way most-recently-used: every node on its path records the way bit
   // taken at that node, so the victim walk steers away from it.
   function automatic tree_max_t plru_update(input tree_max_t tree, input way_max_t way,
                                              input int level);
      tree_max_t t;
      int        node;
      logic      dir;
      t    = tree;
      node = 0;
      for (int l = 0; l < MAX_LEVEL; l++) begin
         if (l < level) begin
            dir     = way[level - 1 - l];
            t[node] = dir;
            node    = 2 * node + 1 + int'(dir);
         end
      end
      return t;
   endfunction

   // Index of the lowest set bit; zero when the mask is empty.
   function automatic way_max_t first_invalid(input mask_max_t mask);
      way_max_t idx;
      logic     found;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_WAYS; i++) begin
         if (!found && mask[i]) begin
            idx   = way_max_t'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/plru_tree_calc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : plru_tree_calc                                               |
// | Description : Combinational tree-PLRU logic for one set: the victim the    |
// |               current tree points at, and the tree after marking upd_way   |
// |               as most-recently-used.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module plru_tree_calc
   import plru_pkg::*;
#(
   parameter int LEVEL = 2
)
(
   input  logic [(1<<LEVEL)-2:0] tree_in,
   input  logic [LEVEL-1:0]      upd_way,
   output logic [LEVEL-1:0]      victim,
   output logic [(1<<LEVEL)-2:0] tree_out
);

   localparam int NODES = (1 << LEVEL) - 1;

   // Victim and post-update tree both derived from the same incoming tree.
   always_comb begin
      victim   = LEVEL'(plru_victim(tree_max_t'(tree_in), LEVEL));
      tree_out = NODES'(plru_update(tree_max_t'(tree_in), way_max_t'(upd_way), LEVEL));
   end

endmodule
`default_nettype wire

// File: rtl/plru_victim_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : plru_victim_select                                           |
// | Description : Per-set tree pseudo-LRU state with an always-accepted touch  |
// |               port and a valid/ready victim request/response engine.       |
// |               Granted victims are committed as MRU on the response         |
// |               handshake.                                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module plru_victim_select
   import plru_pkg::*;
#(
   parameter  int SETS  = 16,
   parameter  int WAYS  = 4,
   localparam int SIDX  = $clog2(SETS),
   localparam int LEVEL = $clog2(WAYS)
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             touch_valid,
   input  logic [SIDX-1:0]  touch_set,
   input  logic [LEVEL-1:0] touch_way,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [SIDX-1:0]  req_set,
   input  logic [WAYS-1:0]  req_inv_mask,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [LEVEL-1:0] resp_way,
   output logic             resp_from_inv
);

   localparam int NODES = WAYS - 1;

   logic [NODES-1:0] tree_q [SETS];
   state_e           state;
   logic [SIDX-1:0]  set_q;
   logic [WAYS-1:0]  mask_q;

   logic             commit;
   logic [LEVEL-1:0] calc_victim;
   logic [LEVEL-1:0] inv_way;
   logic [NODES-1:0] commit_tree;
   logic [NODES-1:0] touch_base;
   logic [NODES-1:0] touch_tree;
   logic [LEVEL-1:0] touch_victim_unused;

   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign commit     = (state == ST_RESP) && resp_ready;

   // The registered set feeds both the CALC victim and the commit update; in
   // CALC the tree is read as it stands at the start of the cycle.
   plru_tree_calc #(
      .LEVEL    (LEVEL)
   ) u_set_calc (
      .tree_in  (tree_q[set_q]),
      .upd_way  (resp_way),
      .victim   (calc_victim),
      .tree_out (commit_tree)
   );

   // A touch landing on the committing set stacks on top of the commit result,
   // so the touched way ends up most recent.
   assign touch_base = (commit && (touch_set == set_q)) ? commit_tree : tree_q[touch_set];

   plru_tree_calc #(
      .LEVEL    (LEVEL)
   ) u_touch_calc (
      .tree_in  (touch_base),
      .upd_way  (touch_way),
      .victim   (touch_victim_unused),
      .tree_out (touch_tree)
   );

   // Lowest-index invalid way of the registered mask.
   always_comb begin
      inv_way = LEVEL'(first_invalid(mask_max_t'(mask_q)));
   end

   // Tree array: commit write first, touch write last so it wins on a shared set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) begin
            tree_q[s] <= '0;
         end
      end else begin
         if (commit) begin
            tree_q[set_q] <= commit_tree;
         end
         if (touch_valid) begin
            tree_q[touch_set] <= touch_tree;
         end
      end
   end

   // Request engine: capture in IDLE, pick victim in CALC, hold it in RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         set_q         <= '0;
         mask_q        <= '0;
         resp_way      <= '0;
         resp_from_inv <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  set_q  <= req_set;
                  mask_q <= req_inv_mask;
                  state  <= ST_CALC;
               end
            end
            ST_CALC: begin
               if (|mask_q) begin
                  resp_way      <= inv_way;
                  resp_from_inv <= 1'b1;
               end else begin
                  resp_way      <= calc_victim;
                  resp_from_inv <= 1'b0;
               end
               state <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_plru_victim_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_plru_victim_select                                        |
// | Description : Self-checking bench for plru_victim_select with a per-level  |
// |               prefix-indexed reference model, directed scenarios and a     |
// |               randomized phase.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_plru_victim_select;

   localparam int SETS  = 16;
   localparam int WAYS  = 4;
   localparam int LEVEL = 2;
   localparam int SIDX  = 4;

   localparam int M_IDLE = 0;
   localparam int M_CALC = 1;
   localparam int M_RESP = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             touch_valid;
   logic [SIDX-1:0]  touch_set;
   logic [LEVEL-1:0] touch_way;
   logic             req_valid;
   logic             req_ready;
   logic [SIDX-1:0]  req_set;
   logic [WAYS-1:0]  req_inv_mask;
   logic             resp_valid;
   logic             resp_ready;
   logic [LEVEL-1:0] resp_way;
   logic             resp_from_inv;

   plru_victim_select #(
      .SETS          (SETS),
      .WAYS          (WAYS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .touch_valid   (touch_valid),
      .touch_set     (touch_set),
      .touch_way     (touch_way),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_set       (req_set),
      .req_inv_mask  (req_inv_mask),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_way      (resp_way),
      .resp_from_inv (resp_from_inv)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference: one pointer bit per (set, level, path prefix).
   bit lvl_bits [SETS][LEVEL][WAYS];
   int m_state;
   int m_set;
   int m_mask;
   int m_way;
   int m_inv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++)
         for (int l = 0; l < LEVEL; l++)
            for (int p = 0; p < WAYS; p++)
               lvl_bits[s][l][p] = 1'b0;
      m_state = M_IDLE;
      m_set   = 0;
      m_mask  = 0;
      m_way   = 0;
      m_inv   = 0;
   endfunction

   function automatic int mvictim(input int s);
      int prefix = 0;
      for (int l = 0; l < LEVEL; l++)
         prefix = prefix * 2 + (lvl_bits[s][l][prefix] ? 0 : 1);
      return prefix;
   endfunction

   function automatic void mtouch(input int s, input int w);
      int prefix = 0;
      int b;
      for (int l = 0; l < LEVEL; l++) begin
         b = (w >> (LEVEL - 1 - l)) & 1;
         lvl_bits[s][l][prefix] = (b == 1);
         prefix = prefix * 2 + b;
      end
   endfunction

   function automatic int lowest(input int mask);
      for (int w = 0; w < WAYS; w++)
         if (((mask >> w) & 1) == 1) return w;
      return 0;
   endfunction

   // One clock: advance the model from the inputs held before the edge, then
   // compare the DUT just after the edge.
   task automatic cycle();
      int nstate = m_state;
      if (m_state == M_IDLE) begin
         if (req_valid) begin
            m_set  = int'(req_set);
            m_mask = int'(req_inv_mask);
            nstate = M_CALC;
         end
      end else if (m_state == M_CALC) begin
         if (m_mask != 0) begin
            m_way = lowest(m_mask);
            m_inv = 1;
         end else begin
            m_way = mvictim(m_set);
            m_inv = 0;
         end
         nstate = M_RESP;
      end else begin
         if (resp_ready) begin
            mtouch(m_set, m_way);
            nstate = M_IDLE;
         end
      end
      if (touch_valid) mtouch(int'(touch_set), int'(touch_way));
      m_state = nstate;
      @(posedge clk);
      #1;
      check("req_ready", 32'(req_ready), 32'(m_state == M_IDLE));
      check("resp_valid", 32'(resp_valid), 32'(m_state == M_RESP));
      if (m_state == M_RESP) begin
         check("resp_way", 32'(resp_way), 32'(m_way));
         check("resp_from_inv", 32'(resp_from_inv), 32'(m_inv));
      end
   endtask

   // Present a request and wait for the response; returns with resp_valid high.
   task automatic begin_request(input int s, input int mask);
      int n = 0;
      while (m_state != M_IDLE && n < 20) begin
         cycle();
         n++;
      end
      req_valid    = 1'b1;
      req_set      = SIDX'(s);
      req_inv_mask = WAYS'(mask);
      cycle();
      req_valid = 1'b0;
      n = 0;
      while (!resp_valid && n < 10) begin
         cycle();
         n++;
      end
      // Accept edge -> CALC; one more edge -> RESP.
      check("latency", 32'(n), 32'd1);
   endtask

   task automatic do_request(input int s, input int mask, input bit ct, input int ct_way,
                             output int way, output int inv);
      begin_request(s, mask);
      way = int'(resp_way);
      inv = int'(resp_from_inv);
      resp_ready = 1'b1;
      if (ct) begin
         touch_valid = 1'b1;
         touch_set   = SIDX'(s);
         touch_way   = LEVEL'(ct_way);
      end
      cycle();
      resp_ready  = 1'b0;
      touch_valid = 1'b0;
   endtask

   initial begin
      int w;
      int inv;
      int exp_w;
      int held;
      int exp1 [4];
      exp1 = '{3, 1, 2, 0};

      touch_valid  = 1'b0;
      touch_set    = '0;
      touch_way    = '0;
      req_valid    = 1'b0;
      req_set      = '0;
      req_inv_mask = '0;
      resp_ready   = 1'b0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_way", 32'(resp_way), 32'd0);
      check("rst_from_inv", 32'(resp_from_inv), 32'd0);
      rst = 1'b1;
      cycle();

      // Back-to-back fills to one fresh set rotate through the ways.
      for (int i = 0; i < 4; i++) begin
         do_request(3, 0, 1'b0, 0, w, inv);
         check("t1_way", 32'(w), 32'(exp1[i]));
         check("t1_inv", 32'(inv), 32'd0);
      end

      // Touch ways 0,1,2 then allocate.
      touch_valid = 1'b1;
      touch_set   = SIDX'(5);
      for (int i = 0; i < 3; i++) begin
         touch_way = LEVEL'(i);
         cycle();
      end
      touch_valid = 1'b0;
      do_request(5, 0, 1'b0, 0, w, inv);
      check("t2_way", 32'(w), 32'd0);

      // Invalid mask takes priority; its commit still updates the tree.
      do_request(7, 4'b0110, 1'b0, 0, w, inv);
      check("t3_way", 32'(w), 32'd1);
      check("t3_inv", 32'(inv), 32'd1);
      exp_w = mvictim(7);
      do_request(7, 0, 1'b0, 0, w, inv);
      check("t3_next_way", 32'(w), 32'(exp_w));
      check("t3_next_inv", 32'(inv), 32'd0);

      // Commit of way 3 and a touch of way 0 on the same edge, same set.
      do_request(2, 0, 1'b1, 0, w, inv);
      check("t4_way", 32'(w), 32'd3);
      do_request(2, 0, 1'b0, 0, w, inv);
      check("t4_next_way", 32'(w), 32'd2);

      // Stall in RESP while touching the same set each cycle.
      begin_request(9, 0);
      held = int'(resp_way);
      check("t5_first_way", 32'(held), 32'd3);
      touch_valid = 1'b1;
      touch_set   = SIDX'(9);
      for (int i = 0; i < 5; i++) begin
         touch_way = LEVEL'($urandom_range(0, WAYS - 1));
         cycle();
         check("t5_hold_way", 32'(resp_way), 32'(held));
         check("t5_hold_ready", 32'(req_ready), 32'd0);
      end
      touch_valid = 1'b0;
      resp_ready  = 1'b1;
      cycle();
      resp_ready = 1'b0;
      exp_w = mvictim(9);
      do_request(9, 0, 1'b0, 0, w, inv);
      check("t5_next_way", 32'(w), 32'(exp_w));

      // Asynchronous reset while a response is pending.
      begin_request(4, 4'b0100);
      rst = 1'b0;
      #1;
      check("t6_resp_valid", 32'(resp_valid), 32'd0);
      check("t6_req_ready", 32'(req_ready), 32'd1);
      check("t6_resp_way", 32'(resp_way), 32'd0);
      check("t6_from_inv", 32'(resp_from_inv), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      cycle();
      do_request(int'($urandom_range(0, SETS - 1)), 0, 1'b0, 0, w, inv);
      check("t6_after_way", 32'(w), 32'd3);

      // Randomized traffic on all ports.
      for (int i = 0; i < 600; i++) begin
         touch_valid  = 1'($urandom_range(0, 1));
         touch_set    = SIDX'($urandom_range(0, SETS - 1));
         touch_way    = LEVEL'($urandom_range(0, WAYS - 1));
         req_valid    = 1'($urandom_range(0, 1));
         req_set      = SIDX'($urandom_range(0, 3));
         req_inv_mask = ($urandom_range(0, 1) == 1) ? WAYS'($urandom_range(0, 15)) : '0;
         resp_ready   = ($urandom_range(0, 2) == 0);
         cycle();
      end
      touch_valid = 1'b0;
      req_valid   = 1'b0;
      resp_ready  = 1'b1;
      repeat (4) cycle();
      resp_ready = 1'b0;

      // Final sweep: every set's victim must agree with the model.
      for (int s = 0; s < SETS; s++) begin
         exp_w = mvictim(s);
         do_request(s, 0, 1'b0, 0, w, inv);
         check("sweep_way", 32'(w), 32'(exp_w));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
